microcode_sequencer_n: RTL and testbench
========================================

# microcode_sequencer_n

Parametrised microcode sequencer for the tau processor. It replaces the fixed execution-driver-plus-load-counter pair with one state machine, and adds three things the earlier pair lacks: conditional micro-branches on ALU flags, micro-subroutine call/return on a bounded stack, and sticky fault flags. It sits between the opcode-to-microcode translation ROM, the microcode ROM, the program counter and the ALU flag bus.

## Interface
- ADDRESS_WIDTH, 16, width of the microcode address and branch target
- FLAG_WIDTH, 8, width of the ALU flag bus
- STACK_DEPTH, 4, return-stack entries (≥1)
- FETCH_CYCLES, 1, wait cycles for the synchronous program RAM read (≥1)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- enable  in  1  run request
- opcode_address  in  ADDRESS_WIDTH  microcode entry point from the translation ROM
- flags  in  FLAG_WIDTH  ALU flags
- finish  in  1  micro-word field: end of instruction
- branch  in  1  micro-word field: conditional jump
- call  in  1  micro-word field: push return address, then jump
- ret  in  1  micro-word field: pop and jump
- flag_select  in  $clog2(FLAG_WIDTH)  flag index tested by a branch
- branch_polarity  in  1  branch is taken when flags[flag_select] equals this value
- branch_target  in  ADDRESS_WIDTH  jump or call target
- microcode_address  out  ADDRESS_WIDTH  registered microcode ROM address
- microcode_rom_read_enable  out  1  high only in EXECUTE
- program_counter_enable  out  1  one-cycle PC advance
- stack_overflow  out  1  sticky fault flag
- stack_underflow  out  1  sticky fault flag
- busy  out  1  high in any state other than IDLE

## Operation
- **States:** IDLE, FETCH, DECODE, EXECUTE.
- **IDLE:** `enable`=1 moves to FETCH on the next edge.
- **FETCH:** lasts exactly FETCH_CYCLES cycles, then moves to DECODE.
- **DECODE:** lasts 1 cycle. `microcode_address` <= `opcode_address`. Moves to EXECUTE.
- **EXECUTE:** each cycle evaluates the current micro-word. Priority is finish > ret > call > branch > increment.
  - **finish:** `program_counter_enable`=1 for this cycle (combinational in EXECUTE). Next state is FETCH if `enable`=1, otherwise IDLE.
  - **ret:**
    - Stack non-empty: pop into `microcode_address`.
    - Stack empty: set `stack_underflow`, go to IDLE, no PC advance.
  - **call:**
    - Stack not full: push `microcode_address`+1, load `branch_target`.
    - Stack full: set `stack_overflow`, go to IDLE, no push.
  - **branch:**
    - Taken (`flags[flag_select]`==`branch_polarity`): load `branch_target`.
    - Not taken: increment.
  - **increment:** `microcode_address`+1, modulo 2^ADDRESS_WIDTH. The all-ones address wraps to 0, with no flag raised.
- **Deasserting `enable`:** mid-instruction it takes effect only at `finish`. FETCH and DECODE always run to completion.
- **Fault flags:** set once, cleared only by `reset`. While either fault flag is set, IDLE ignores `enable`.
- **Return stack:** a LIFO. The push to entry STACK_DEPTH-1 is legal; the next push overflows. The stack is not cleared at `finish`. Leftover entries persist, and that is software's responsibility.

## Timing
- **Reset values:**
  - state = IDLE
  - `microcode_address` = 0
  - `microcode_rom_read_enable` = 0
  - `program_counter_enable` = 0
  - `stack_overflow` = 0
  - `stack_underflow` = 0
  - `busy` = 0
  - stack pointer = 0 (stack empty)
- **Reset mid-operation:** takes effect immediately and asynchronously. No PC pulse completes.
- **Instruction length:** k sequential micro-words with no jumps take FETCH_CYCLES + 1 + k cycles from the first FETCH cycle to the cycle after `finish`.
- **Jumps:** a taken branch, call or ret takes effect in the next cycle's `microcode_address`. A taken jump costs no bubble.
- **Back-to-back instructions:** with `enable` held high, consecutive `program_counter_enable` pulses are FETCH_CYCLES + 1 + k cycles apart.
- **Flags:** `flags` is sampled in the same EXECUTE cycle as the branch word.

## Test plan
- **Reset and start:** reset, then `enable`=1; opcode_address=0x0010; the micro-word at 0x0011 has finish=1 (FETCH_CYCLES=1) -> 1 FETCH, 1 DECODE, EXECUTE at 0x0010 then 0x0011; one `program_counter_enable` pulse; back to FETCH.
- **Branch both polarities:** branch at 0x0020, target 0x0030, flag_select=2, polarity=1. flags=0x04 -> next address 0x0030. flags=0x00 -> next address 0x0021.
- **Call/return:** call at 0x0005 to 0x0040; ret at 0x0041 -> sequence 0x0005, 0x0040, 0x0041, 0x0006; stack empty afterwards.
- **Stack limits (STACK_DEPTH=4):**
  - Five nested calls -> `stack_overflow`=1 on the fifth; IDLE; `enable` then ignored until reset.
  - ret with an empty stack -> `stack_underflow`=1.
- **Wrap and enable drop:**
  - Increment from 0xFFFF -> 0x0000.
  - Drop `enable` during a 3-word instruction -> completes through `finish`, one PC pulse, IDLE, `busy`=0.
- **Asynchronous reset:** assert `reset` between clock edges in EXECUTE -> all outputs at reset values before the next edge.

Source files
------------

// File: rtl/microcode_sequencer_n.sv
// Microcode sequencer for the tau processor: fetch/decode/execute control
// with flag branches, a bounded call/return stack and sticky fault flags.
module microcode_sequencer_n #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int FLAG_WIDTH    = 8,
  parameter int STACK_DEPTH   = 4,
  parameter int FETCH_CYCLES  = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [ADDRESS_WIDTH-1:0]      opcode_address,
  input  logic [FLAG_WIDTH-1:0]         flags,
  input  logic                          finish,
  input  logic                          branch,
  input  logic                          call,
  input  logic                          ret,
  input  logic [$clog2(FLAG_WIDTH)-1:0] flag_select,
  input  logic                          branch_polarity,
  input  logic [ADDRESS_WIDTH-1:0]      branch_target,
  output logic [ADDRESS_WIDTH-1:0]      microcode_address,
  output logic                          microcode_rom_read_enable,
  output logic                          program_counter_enable,
  output logic                          stack_overflow,
  output logic                          stack_underflow,
  output logic                          busy
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int FC_W  = (FETCH_CYCLES > 1) ? $clog2(FETCH_CYCLES) : 1;

  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FETCH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE
  } state_t;

  state_t                   state, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_d;
  logic [ADDRESS_WIDTH-1:0] addr_inc;
  logic [SP_W-1:0]          sp, sp_d;
  logic [FC_W-1:0]          fcnt, fcnt_d;
  logic                     ovf_d, unf_d;
  logic                     push;
  logic                     taken;
  logic [IDX_W-1:0]         push_idx, pop_idx;
  logic [ADDRESS_WIDTH-1:0] stack [STACK_DEPTH];

  assign addr_inc = microcode_address + 1'b1;
  assign push_idx = IDX_W'(sp);
  assign pop_idx  = IDX_W'(sp - 1'b1);
  assign taken    = (flags[flag_select] == branch_polarity);
  assign busy     = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      microcode_address <= '0;
      sp                <= '0;
      fcnt              <= '0;
      stack_overflow    <= 1'b0;
      stack_underflow   <= 1'b0;
    end else begin
      state             <= state_d;
      microcode_address <= addr_d;
      sp                <= sp_d;
      fcnt              <= fcnt_d;
      stack_overflow    <= ovf_d;
      stack_underflow   <= unf_d;
    end
  end

  // Stack contents need no reset: entries are only read below sp.
  always_ff @(posedge clock) begin
    if (push) stack[push_idx] <= addr_inc;
  end

  always_comb begin
    state_d                   = state;
    addr_d                    = microcode_address;
    sp_d                      = sp;
    fcnt_d                    = fcnt;
    ovf_d                     = stack_overflow;
    unf_d                     = stack_underflow;
    push                      = 1'b0;
    microcode_rom_read_enable = 1'b0;
    program_counter_enable    = 1'b0;
    unique case (state)
      IDLE: begin
        fcnt_d = '0;
        if (enable && !stack_overflow && !stack_underflow)
          state_d = FETCH;
      end
      FETCH: begin
        if (fcnt == FC_LAST) begin
          fcnt_d  = '0;
          state_d = DECODE;
        end else begin
          fcnt_d = fcnt + 1'b1;
        end
      end
      DECODE: begin
        addr_d  = opcode_address;
        state_d = EXECUTE;
      end
      EXECUTE: begin
        microcode_rom_read_enable = 1'b1;
        priority case (1'b1)
          finish: begin
            program_counter_enable = 1'b1;
            state_d = enable ? FETCH : IDLE;
          end
          ret: begin
            if (sp != '0) begin
              addr_d = stack[pop_idx];
              sp_d   = sp - 1'b1;
            end else begin
              unf_d   = 1'b1;
              state_d = IDLE;
            end
          end
          call: begin
            if (sp != SP_FULL) begin
              push   = 1'b1;
              sp_d   = sp + 1'b1;
              addr_d = branch_target;
            end else begin
              ovf_d   = 1'b1;
              state_d = IDLE;
            end
          end
          branch: begin
            addr_d = taken ? branch_target : addr_inc;
          end
          default: begin
            addr_d = addr_inc;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_microcode_sequencer_n.sv
// Directed bench for microcode_sequencer_n: a micro-ROM model feeds word
// fields, and a queue holds the expected EXECUTE address sequence.
module tb_microcode_sequencer_n;

  typedef struct packed {
    logic        fin;
    logic        rt;
    logic        cl;
    logic        br;
    logic        pol;
    logic [2:0]  sel;
    logic [15:0] tgt;
  } uword_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] opcode_address = '0;
  logic [7:0]  flags = '0;
  logic        finish, branch, call, ret;
  logic [2:0]  flag_select;
  logic        branch_polarity;
  logic [15:0] branch_target;
  logic [15:0] microcode_address;
  logic        microcode_rom_read_enable;
  logic        program_counter_enable;
  logic        stack_overflow;
  logic        stack_underflow;
  logic        busy;

  uword_t      w = '0;
  uword_t      rom [logic [15:0]];
  logic [15:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          pc_cnt = 0;
  int          cyc = 0;
  int          pc_cyc [$];

  assign finish          = w.fin;
  assign ret             = w.rt;
  assign call            = w.cl;
  assign branch          = w.br;
  assign branch_polarity = w.pol;
  assign flag_select     = w.sel;
  assign branch_target   = w.tgt;

  microcode_sequencer_n #(
    .ADDRESS_WIDTH(16),
    .FLAG_WIDTH(8),
    .STACK_DEPTH(4),
    .FETCH_CYCLES(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .opcode_address(opcode_address),
    .flags(flags),
    .finish(finish),
    .branch(branch),
    .call(call),
    .ret(ret),
    .flag_select(flag_select),
    .branch_polarity(branch_polarity),
    .branch_target(branch_target),
    .microcode_address(microcode_address),
    .microcode_rom_read_enable(microcode_rom_read_enable),
    .program_counter_enable(program_counter_enable),
    .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow),
    .busy(busy)
  );

  initial forever #5 clock = ~clock;

  function automatic uword_t lookup(logic [15:0] a);
    if (rom.exists(a)) return rom[a];
    return '0;
  endfunction

  function automatic uword_t mk(logic fin, logic rt, logic cl, logic br,
                                logic pol, logic [2:0] sel, logic [15:0] tgt);
    uword_t u;
    u.fin = fin; u.rt = rt; u.cl = cl; u.br = br;
    u.pol = pol; u.sel = sel; u.tgt = tgt;
    return u;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: refresh the micro-word, then sample and score.
  task automatic step();
    logic [15:0] e;
    @(posedge clock);
    #1 w = lookup(microcode_address);
    #1 cyc++;
    if (program_counter_enable) begin
      pc_cnt++;
      pc_cyc.push_back(cyc);
    end
    if (microcode_rom_read_enable) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underrun observed=%0h expected=none",
               microcode_address);
      end else begin
        e = exp_q.pop_front();
        chk("exec_addr", {16'h0, microcode_address}, {16'h0, e});
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    flags = '0;
    opcode_address = '0;
    exp_q.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    w = lookup(microcode_address);
    #1 pc_cnt = 0;
    cyc = 0;
    pc_cyc.delete();
  endtask

  task automatic run_instr(string tag, logic [15:0] op, int k);
    pc_cnt = 0;
    opcode_address = op;
    enable = 1'b1;
    step();
    enable = 1'b0;
    repeat (2 + k) step();
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_pc"}, pc_cnt, 1);
    chk({tag, "_q"}, exp_q.size(), 0);
  endtask

  initial begin
    // Reset values
    do_reset();
    chk("rst_addr", {16'h0, microcode_address}, 32'h0);
    chk("rst_rom_en", {31'h0, microcode_rom_read_enable}, 32'h0);
    chk("rst_pc_en", {31'h0, program_counter_enable}, 32'h0);
    chk("rst_ovf", {31'h0, stack_overflow}, 32'h0);
    chk("rst_unf", {31'h0, stack_underflow}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);

    // Start: 0x10 then 0x11 (finish), back to FETCH with enable held
    rom.delete();
    rom[16'h0011] = mk(1, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(16'h0010);
    exp_q.push_back(16'h0011);
    opcode_address = 16'h0010;
    enable = 1'b1;
    step();
    chk("start_busy", {31'h0, busy}, 32'h1);
    chk("start_fetch_rom", {31'h0, microcode_rom_read_enable}, 32'h0);
    repeat (4) step();
    chk("start_pc", pc_cnt, 1);
    chk("start_refetch_busy", {31'h0, busy}, 32'h1);
    chk("start_refetch_rom", {31'h0, microcode_rom_read_enable}, 32'h0);
    chk("start_q", exp_q.size(), 0);

    // Branch taken
    do_reset();
    rom.delete();
    rom[16'h0020] = mk(0, 0, 0, 1, 1, 3'd2, 16'h0030);
    rom[16'h0030] = mk(1, 0, 0, 0, 0, 0, 0);
    rom[16'h0021] = mk(1, 0, 0, 0, 0, 0, 0);
    flags = 8'h04;
    exp_q.push_back(16'h0020);
    exp_q.push_back(16'h0030);
    run_instr("br_taken", 16'h0020, 2);

    // Branch not taken
    flags = 8'h00;
    exp_q.push_back(16'h0020);
    exp_q.push_back(16'h0021);
    run_instr("br_not", 16'h0020, 2);

    // Call / return
    do_reset();
    rom.delete();
    rom[16'h0005] = mk(0, 0, 1, 0, 0, 0, 16'h0040);
    rom[16'h0041] = mk(0, 1, 0, 0, 0, 0, 0);
    rom[16'h0006] = mk(1, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(16'h0005);
    exp_q.push_back(16'h0040);
    exp_q.push_back(16'h0041);
    exp_q.push_back(16'h0006);
    run_instr("callret", 16'h0005, 4);

    // Stack now empty: a ret underflows
    pc_cnt = 0;
    exp_q.push_back(16'h0041);
    opcode_address = 16'h0041;
    enable = 1'b1;
    repeat (3) step();
    chk("unf_before", {31'h0, stack_underflow}, 32'h0);
    step();
    chk("unf_set", {31'h0, stack_underflow}, 32'h1);
    chk("unf_busy", {31'h0, busy}, 32'h0);
    chk("unf_pc", pc_cnt, 0);
    repeat (3) step();
    chk("unf_ignore_en", {31'h0, busy}, 32'h0);

    // Overflow on the fifth nested call
    do_reset();
    rom.delete();
    for (int i = 0; i < 5; i++) begin
      rom[16'h0060 + 16'(i)] = mk(0, 0, 1, 0, 0, 0, 16'h0061 + 16'(i));
      exp_q.push_back(16'h0060 + 16'(i));
    end
    opcode_address = 16'h0060;
    enable = 1'b1;
    repeat (7) step();
    chk("ovf_before", {31'h0, stack_overflow}, 32'h0);
    step();
    chk("ovf_set", {31'h0, stack_overflow}, 32'h1);
    chk("ovf_unf", {31'h0, stack_underflow}, 32'h0);
    chk("ovf_busy", {31'h0, busy}, 32'h0);
    chk("ovf_q", exp_q.size(), 0);
    repeat (3) step();
    chk("ovf_ignore_en", {31'h0, busy}, 32'h0);
    do_reset();
    chk("ovf_cleared", {31'h0, stack_overflow}, 32'h0);

    // Address wrap
    rom.delete();
    rom[16'h0000] = mk(1, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    run_instr("wrap", 16'hFFFF, 2);
    chk("wrap_ovf", {31'h0, stack_overflow}, 32'h0);

    // Enable drop mid-instruction
    do_reset();
    rom.delete();
    rom[16'h0052] = mk(1, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(16'h0050);
    exp_q.push_back(16'h0051);
    exp_q.push_back(16'h0052);
    opcode_address = 16'h0050;
    enable = 1'b1;
    repeat (3) step();
    enable = 1'b0;
    repeat (3) step();
    chk("drop_busy", {31'h0, busy}, 32'h0);
    chk("drop_pc", pc_cnt, 1);
    chk("drop_q", exp_q.size(), 0);

    // Back-to-back pulses FETCH_CYCLES+1+k apart
    do_reset();
    rom.delete();
    rom[16'h0011] = mk(1, 0, 0, 0, 0, 0, 0);
    repeat (2) begin
      exp_q.push_back(16'h0010);
      exp_q.push_back(16'h0011);
    end
    opcode_address = 16'h0010;
    enable = 1'b1;
    repeat (5) step();
    enable = 1'b0;
    repeat (4) step();
    chk("b2b_pc", pc_cnt, 2);
    if (pc_cyc.size() == 2)
      chk("b2b_gap", pc_cyc[1] - pc_cyc[0], 4);
    else
      chk("b2b_pulses", pc_cyc.size(), 2);
    chk("b2b_busy", {31'h0, busy}, 32'h0);

    // Asynchronous reset during EXECUTE
    do_reset();
    rom.delete();
    rom[16'h0071] = mk(1, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(16'h0070);
    exp_q.push_back(16'h0071);
    opcode_address = 16'h0070;
    enable = 1'b1;
    repeat (4) step();
    chk("arst_pre_pc", {31'h0, program_counter_enable}, 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("arst_addr", {16'h0, microcode_address}, 32'h0);
    chk("arst_rom_en", {31'h0, microcode_rom_read_enable}, 32'h0);
    chk("arst_pc_en", {31'h0, program_counter_enable}, 32'h0);
    chk("arst_busy", {31'h0, busy}, 32'h0);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
